// File: rtl/fft_seq_ctrl.sv
// Sequencer for a 32-point radix-2 DIT FFT: bit-reversed load, log2(N) stages of N/2 butterflies on one shared unit, natural-order unload.
// Latency: first butterfly issued the cycle after the last load handshake; write-back trails each issue by BF_LAT cycles.
// Backpressure: in_valid low stalls loading, out_ready low holds out_addr; the butterfly issue stream is never stalled.
module fft_seq_ctrl #(
    parameter int N_LOG2 = 5,
    parameter int BF_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              load_we,
    output logic [N_LOG2-1:0] load_addr,
    output logic              bf_issue,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [N_LOG2-2:0] tw_idx,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b,
    output logic [2:0]        stage,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_LOG2-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam int WW = (BF_LAT < 2) ? 1 : $clog2(BF_LAT + 1);
    localparam logic [N_LOG2-1:0] CNT_LAST  = '1;
    localparam logic [N_LOG2-2:0] K_LAST    = '1;
    localparam logic [2:0]        S_LAST    = 3'(N_LOG2 - 1);
    localparam logic [WW-1:0]     WAIT_INIT = WW'(BF_LAT);
    localparam logic [WW-1:0]     WAIT_ONE  = WW'(1);
    localparam logic [N_LOG2-1:0] ONE       = N_LOG2'(1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, UNLOAD} state_t;

    state_t              state, state_nxt;
    logic [N_LOG2-1:0]   cnt;        // load count, reused as unload count
    logic [N_LOG2-2:0]   k;          // butterfly index within the stage
    logic [2:0]          s;          // stage index
    logic [WW-1:0]       wait_cnt;   // drain counter between stages
    logic                done_q;
    logic [N_LOG2-1:0]   addr_a_c, addr_b_c;
    logic [N_LOG2-2:0]   tw_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = LOAD;
            LOAD:   if (in_valid && cnt == CNT_LAST) state_nxt = RUN;
            RUN:    if (k == K_LAST && !(BF_LAT == 0 && s < S_LAST)) state_nxt = WAIT;
            WAIT:   if (wait_cnt <= WAIT_ONE) state_nxt = (s < S_LAST) ? RUN : UNLOAD;
            UNLOAD: if (out_ready && cnt == CNT_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load/unload count, butterfly index, stage, drain counter and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            k        <= '0;
            s        <= '0;
            wait_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        k   <= '0;
                        s   <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        cnt <= cnt + ONE;
                        if (cnt == CNT_LAST) begin
                            k <= '0;
                            s <= '0;
                        end
                    end
                end
                RUN: begin
                    k <= k + (N_LOG2-1)'(1);
                    if (k == K_LAST) begin
                        // A zero-latency butterfly needs no drain between stages
                        if (BF_LAT == 0 && s < S_LAST) s <= s + 3'd1;
                        else                           wait_cnt <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt <= WAIT_ONE) begin
                        if (s < S_LAST) begin
                            s <= s + 3'd1;
                            k <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_ONE;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        cnt <= cnt + ONE;
                        if (cnt == CNT_LAST) begin
                            s      <= '0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Butterfly operand addresses and twiddle index from (stage, k)
    always_comb begin
        logic [N_LOG2-1:0] kx, half, pos, grp;
        kx       = {1'b0, k};
        half     = ONE << s;
        pos      = kx & (half - ONE);
        grp      = kx >> s;
        addr_a_c = (grp << (s + 3'd1)) | pos;
        addr_b_c = addr_a_c + half;
        tw_c     = pos[N_LOG2-2:0] << (S_LAST - s);
    end

    // Output decode; addresses are forced to zero outside their phase
    always_comb begin
        in_ready  = 1'b0;
        load_we   = 1'b0;
        load_addr = '0;
        bf_issue  = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_idx    = '0;
        out_valid = 1'b0;
        out_addr  = '0;
        busy      = (state != IDLE);
        stage     = s;
        done      = done_q;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                load_we  = in_valid;
                for (int i = 0; i < N_LOG2; i++) load_addr[i] = cnt[N_LOG2-1-i];
            end
            RUN: begin
                bf_issue  = 1'b1;
                rd_addr_a = addr_a_c;
                rd_addr_b = addr_b_c;
                tw_idx    = tw_c;
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_addr  = cnt;
            end
            default: ;
        endcase
    end

    generate
        if (BF_LAT == 0) begin : g_nopipe
            assign wr_en     = bf_issue;
            assign wr_addr_a = rd_addr_a;
            assign wr_addr_b = rd_addr_b;
        end else begin : g_pipe
            logic [BF_LAT-1:0] p_vld;
            logic [N_LOG2-1:0] p_a [BF_LAT];
            logic [N_LOG2-1:0] p_b [BF_LAT];

            // Write-back delay line; reset drops any writes still in flight
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_vld <= '0;
                    for (int i = 0; i < BF_LAT; i++) begin
                        p_a[i] <= '0;
                        p_b[i] <= '0;
                    end
                end else begin
                    p_vld[0] <= bf_issue;
                    p_a[0]   <= rd_addr_a;
                    p_b[0]   <= rd_addr_b;
                    for (int i = 1; i < BF_LAT; i++) begin
                        p_vld[i] <= p_vld[i-1];
                        p_a[i]   <= p_a[i-1];
                        p_b[i]   <= p_b[i-1];
                    end
                end
            end

            assign wr_en     = p_vld[BF_LAT-1];
            assign wr_addr_a = p_a[BF_LAT-1];
            assign wr_addr_b = p_b[BF_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: load order, butterfly schedule, drain gaps, backpressure, done, reset abort.
// A second instance with zero butterfly latency checks the gap-free issue stream.
// Inputs change and outputs are sampled in the low phase of the clock.
module tb_fft_seq_ctrl;

    localparam int BL = 2;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic b_out_ready = 1'b1;

    logic       in_ready, load_we, bf_issue, wr_en, out_valid, busy, done;
    logic [4:0] load_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, out_addr;
    logic [3:0] tw_idx;
    logic [2:0] stage;

    logic       b_in_ready, b_load_we, b_bf_issue, b_wr_en, b_out_valid, b_busy, b_done;
    logic [4:0] b_load_addr, b_rd_addr_a, b_rd_addr_b, b_wr_addr_a, b_wr_addr_b, b_out_addr;
    logic [3:0] b_tw_idx;
    logic [2:0] b_stage;

    fft_seq_ctrl #(.N_LOG2(5), .BF_LAT(BL)) u0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .load_we(load_we), .load_addr(load_addr), .bf_issue(bf_issue), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .tw_idx(tw_idx), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b), .stage(stage), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .busy(busy), .done(done)
    );

    fft_seq_ctrl #(.N_LOG2(5), .BF_LAT(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_ready(b_in_ready),
        .load_we(b_load_we), .load_addr(b_load_addr), .bf_issue(b_bf_issue), .rd_addr_a(b_rd_addr_a),
        .rd_addr_b(b_rd_addr_b), .tw_idx(b_tw_idx), .wr_en(b_wr_en), .wr_addr_a(b_wr_addr_a),
        .wr_addr_b(b_wr_addr_b), .stage(b_stage), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_addr(b_out_addr), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, errors = 0;

    typedef struct { logic iv; logic we; logic [4:0] addr; } ld_vec_t;
    typedef struct { logic rdy; logic st; logic [4:0] addr; } ul_vec_t;
    typedef struct { int s; int k; int a; int b; int tw; } hv_t;

    ld_vec_t ld_q[$];
    ul_vec_t ul_q[$];
    hv_t     hv[3];
    int br_tab[32] = '{0,16,8,24,4,20,12,28,2,18,10,26,6,22,14,30,
                       1,17,9,25,5,21,13,29,3,19,11,27,7,23,15,31};

    bit exp_vld[100];
    int exp_a[100], exp_b[100], exp_tw[100], exp_st[100];
    int cap_a[80], cap_b[80], cap_tw[80];
    int n_iss, r_cyc;

    // Zero-latency instance monitor
    int b_n = 0, b_first = -1, b_last = -1, b_mis = 0;
    always @(negedge clk) begin
        #2;
        if (b_bf_issue === 1'b1) begin
            if (b_first < 0) b_first = cyc;
            b_last = cyc;
            b_n++;
        end
        if (b_wr_en !== b_bf_issue || b_wr_addr_a !== b_rd_addr_a || b_wr_addr_b !== b_rd_addr_b) b_mis++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cyc_in(input logic st, input logic iv, input logic rdy);
        @(negedge clk);
        start = st; start1 = 1'b0; in_valid = iv; out_ready = rdy;
        #1;
    endtask

    task automatic do_start(input logic both);
        @(negedge clk);
        start = 1'b1; start1 = both; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_in_ready", in_ready, 0);
    endtask

    task automatic load_tbl();
        foreach (ld_q[i]) begin
            cyc_in(1'b0, ld_q[i].iv, 1'b0);
            chk($sformatf("in_ready[%0d]", i), in_ready, 1);
            chk($sformatf("busy_load[%0d]", i), busy, 1);
            chk($sformatf("load_we[%0d]", i), load_we, ld_q[i].we);
            chk($sformatf("load_addr[%0d]", i), load_addr, ld_q[i].addr);
        end
    endtask

    task automatic run_chk(input int last_o);
        n_iss = 0;
        for (int o = 0; o <= last_o; o++) begin
            cyc_in(1'b0, 1'b0, 1'b0);
            if (o == 0) r_cyc = cyc;
            chk($sformatf("bf_issue@R+%0d", o), bf_issue, exp_vld[o]);
            if (exp_vld[o]) begin
                chk($sformatf("rd_addr_a@R+%0d", o), rd_addr_a, exp_a[o]);
                chk($sformatf("rd_addr_b@R+%0d", o), rd_addr_b, exp_b[o]);
                chk($sformatf("tw_idx@R+%0d", o), tw_idx, exp_tw[o]);
                chk($sformatf("stage@R+%0d", o), stage, exp_st[o]);
                if (n_iss < 80) begin
                    cap_a[n_iss] = rd_addr_a; cap_b[n_iss] = rd_addr_b; cap_tw[n_iss] = tw_idx;
                end
                n_iss++;
            end
            if (o >= BL) begin
                chk($sformatf("wr_en@R+%0d", o), wr_en, exp_vld[o-BL]);
                if (exp_vld[o-BL]) begin
                    chk($sformatf("wr_addr_a@R+%0d", o), wr_addr_a, exp_a[o-BL]);
                    chk($sformatf("wr_addr_b@R+%0d", o), wr_addr_b, exp_b[o-BL]);
                end
            end else begin
                chk($sformatf("wr_en@R+%0d", o), wr_en, 0);
            end
            chk($sformatf("out_valid@R+%0d", o), out_valid, (o >= 90) ? 1 : 0);
        end
    endtask

    task automatic unload_tbl();
        foreach (ul_q[i]) begin
            cyc_in(ul_q[i].st, 1'b0, ul_q[i].rdy);
            chk($sformatf("out_valid_ul[%0d]", i), out_valid, 1);
            chk($sformatf("out_addr[%0d]", i), out_addr, ul_q[i].addr);
            chk($sformatf("done_ul[%0d]", i), done, 0);
            chk($sformatf("busy_ul[%0d]", i), busy, 1);
            chk($sformatf("in_ready_ul[%0d]", i), in_ready, 0);
        end
        cyc_in(1'b0, 1'b0, 1'b0);
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("out_valid_at_done", out_valid, 0);
        cyc_in(1'b0, 1'b0, 1'b0);
        chk("done_single", done, 0);
        chk("busy_after_done", busy, 0);
        chk("in_ready_after_done", in_ready, 0);
    endtask

    initial begin
        // Load vectors: 32 handshakes with two in_valid gaps
        for (int i = 0; i < 32; i++) begin
            ld_q.push_back('{iv: 1'b1, we: 1'b1, addr: 5'(br_tab[i])});
            if (i == 1 || i == 20) ld_q.push_back('{iv: 1'b0, we: 1'b0, addr: 5'(br_tab[i+1])});
        end
        // Unload vectors: out_ready 1,0,0,1 then steady, with a stray start mid-unload
        ul_q.push_back('{rdy: 1'b1, st: 1'b0, addr: 5'd0});
        ul_q.push_back('{rdy: 1'b0, st: 1'b0, addr: 5'd1});
        ul_q.push_back('{rdy: 1'b0, st: 1'b0, addr: 5'd1});
        ul_q.push_back('{rdy: 1'b1, st: 1'b0, addr: 5'd1});
        for (int i = 2; i < 32; i++) ul_q.push_back('{rdy: 1'b1, st: (i == 10), addr: 5'(i)});
        // Hand-computed butterfly spot checks
        hv[0] = '{s: 0, k: 3,  a: 6,  b: 7,  tw: 0};
        hv[1] = '{s: 2, k: 5,  a: 9,  b: 13, tw: 4};
        hv[2] = '{s: 4, k: 15, a: 15, b: 31, tw: 15};
        // Expected issue schedule: 16 butterflies per stage, BL idle cycles between stages
        for (int s = 0; s < 5; s++) begin
            int h, idx;
            h = 1 << s;
            idx = 0;
            for (int base = 0; base < 32; base += 2*h) begin
                for (int j = 0; j < h; j++) begin
                    int o;
                    o = s*(16+BL) + idx;
                    exp_vld[o] = 1'b1;
                    exp_a[o] = base + j;
                    exp_b[o] = base + j + h;
                    exp_tw[o] = j * (16 / h);
                    exp_st[o] = s;
                    idx++;
                end
            end
        end

        // Reset state
        @(negedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_bf_issue", bf_issue, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_load_addr", load_addr, 0);
        chk("rst_rd_addr_b", rd_addr_b, 0);
        chk("rst_stage", stage, 0);
        rst = 1'b0;

        // Transform 1: gapped load, full schedule, backpressured unload
        do_start(1'b1);
        load_tbl();
        run_chk(90);
        chk("out_addr_first", out_addr, 0);
        foreach (hv[i]) begin
            chk($sformatf("hand_a_s%0d_k%0d", hv[i].s, hv[i].k), cap_a[hv[i].s*16+hv[i].k], hv[i].a);
            chk($sformatf("hand_b_s%0d_k%0d", hv[i].s, hv[i].k), cap_b[hv[i].s*16+hv[i].k], hv[i].b);
            chk($sformatf("hand_tw_s%0d_k%0d", hv[i].s, hv[i].k), cap_tw[hv[i].s*16+hv[i].k], hv[i].tw);
        end
        chk("issue_count", n_iss, 80);
        unload_tbl();
        chk("lat0_issue_count", b_n, 80);
        chk("lat0_first_issue", b_first, r_cyc);
        chk("lat0_contiguous", b_last - b_first, 79);
        chk("lat0_wr_mirror", b_mis, 0);

        // Transform aborted by reset in stage 2 with writes in flight
        do_start(1'b0);
        load_tbl();
        run_chk(2*(16+BL) + 5);
        rst = 1'b1;
        #1;
        chk("abort_wr_en", wr_en, 0);
        chk("abort_bf_issue", bf_issue, 0);
        chk("abort_busy", busy, 0);
        chk("abort_stage", stage, 0);
        chk("abort_rd_addr_a", rd_addr_a, 0);
        chk("abort_tw_idx", tw_idx, 0);
        chk("abort_wr_addr_a", wr_addr_a, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            cyc_in(1'b0, 1'b0, 1'b0);
            chk($sformatf("abort_hold_wr_en[%0d]", i), wr_en, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc_in(1'b0, 1'b0, 1'b0);
            chk($sformatf("post_abort_wr_en[%0d]", i), wr_en, 0);
            chk($sformatf("post_abort_busy[%0d]", i), busy, 0);
        end

        // Transform 2 after the abort
        do_start(1'b0);
        load_tbl();
        run_chk(90);
        chk("issue_count_2", n_iss, 80);
        unload_tbl();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Sequencer for the 32-point radix-2 decimation-in-time FFT datapath. It owns the shared in-place sample memory and the single shared butterfly unit, and runs each transform in three phases:
- accepts time samples into memory in bit-reversed order;
- issues all N/2 butterflies of each of the log2(N) stages with the correct operand addresses and twiddle index, stalling at stage boundaries for the butterfly pipeline to drain;
- streams results out in natural order.

It replaces the fixed, fully unrolled stage wiring with one time-multiplexed butterfly.

## Interface
- N_LOG2, 5: log2 of transform length N (N=32).
- BF_LAT, 2: butterfly latency in cycles, from bf_issue to the matching wr_en (0 allowed).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin transform; sampled only in IDLE.
- in_valid  in  1  input sample present.
- in_ready  out  1  controller accepts sample (LOAD state).
- load_we  out  1  = in_valid & in_ready; memory write strobe for load.
- load_addr  out  N_LOG2  bit-reversed load counter.
- bf_issue  out  1  butterfly operands valid this cycle.
- rd_addr_a, rd_addr_b  out  N_LOG2 each  butterfly operand addresses.
- tw_idx  out  N_LOG2-1  twiddle index k for W_N^k.
- wr_en  out  1  butterfly result write; bf_issue delayed BF_LAT cycles.
- wr_addr_a, wr_addr_b  out  N_LOG2 each  rd_addr_a/b delayed BF_LAT cycles.
- stage  out  3  current stage 0..N_LOG2-1.
- out_valid  out  1  result available at out_addr.
- out_ready  in  1  consumer accepts result.
- out_addr  out  N_LOG2  natural-order unload counter.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after last unload handshake.

## Operation
- FSM states: IDLE, LOAD, RUN, WAIT, UNLOAD.
- IDLE:
  - start=1 -> LOAD; load counter cleared.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - Each in_valid handshake writes load_addr = bitrev(cnt) and increments cnt.
  - The handshake with cnt=N-1 -> RUN with s=0, k=0.
  - in_valid low stalls with no change.
- RUN: one butterfly issued per cycle, bf_issue=1, for k = 0..N/2-1 with:
  - half = 1<<s, group = k>>s, pos = k&(half-1);
  - rd_addr_a = group*2*half + pos;
  - rd_addr_b = rd_addr_a + half;
  - tw_idx = pos<<(N_LOG2-1-s).
- End of stage (k = N/2-1):
  - if BF_LAT=0 and s<N_LOG2-1: s++, k=0, remain in RUN;
  - otherwise -> WAIT with a counter loaded to BF_LAT.
- WAIT:
  - bf_issue=0; counter decrements each cycle.
  - At 0: if s<N_LOG2-1, then s++, k=0 -> RUN; else -> UNLOAD.
  - For the final stage, WAIT lasts until the last wr_en has been asserted.
- UNLOAD:
  - out_valid=1, out_addr = unload count.
  - Each out_valid & out_ready increments the count.
  - The handshake at N-1 -> IDLE with done=1 in that next cycle.
  - out_ready low holds out_addr stable.
- Write pipeline: a BF_LAT-deep shift register carries {bf_issue, rd_addr_a, rd_addr_b}. It is independent of FSM state and flushes naturally during WAIT.
- Memory contract: reads are combinational. A write in cycle t is visible to a read in t+1.

## Timing
- Reset values (asynchronous, immediate): state=IDLE; all counters 0; in_ready, load_we, bf_issue, wr_en, out_valid, busy and done all 0; all address, tw_idx and stage outputs 0; pipeline cleared.
- Reset mid-transform aborts with no further wr_en, including writes still in flight.
- start at cycle 0 (IDLE): busy=1 and in_ready=1 from cycle 1.
- Last load handshake in cycle L: first bf_issue in cycle L+1 = R.
- Stage boundary: last issue of stage s in cycle t; first issue of stage s+1 in cycle t+BF_LAT+1.
- Compute span, first issue to last wr_en: 80 + 4*BF_LAT + BF_LAT cycles. With BF_LAT=2: last issue at R+87, last wr_en at R+89, out_valid first high at R+90.
- done rises the cycle after the final out handshake, with busy=0 in that same cycle.
- A start asserted in that same cycle is accepted, because the FSM is in IDLE.

## Test plan
- Load bit-reversal: start, then 32 samples with in_valid held high -> load_addr sequence 0,16,8,24,4,...,15,31 on consecutive cycles; in_valid gaps stall load_addr.
- Stage 0 addresses: bf_issue cycle k=3 -> rd_addr_a=6, rd_addr_b=7, tw_idx=0.
- Stage 2 addresses: k=5 -> rd_addr_a=9, rd_addr_b=13, tw_idx=4. Stage 4, k=15 -> rd_addr_a=15, rd_addr_b=31, tw_idx=15.
- Pipeline gaps: with BF_LAT=2, exactly 2 idle bf_issue cycles between stages. wr_en mirrors bf_issue 2 cycles later with matching addresses. out_valid first high at R+90. Repeat with BF_LAT=0: 80 contiguous issues.
- Backpressure and done: out_ready toggled 1,0,0,1 -> out_addr holds during the stalls. done is a single pulse after the out_addr=31 handshake. start while busy is ignored.
- Reset mid-RUN: assert rst at stage 2 with 2 writes in flight -> wr_en never rises again and all outputs are at reset values immediately. A new start then runs a full correct transform.
